// File: rtl/conv_sched_pkg.sv
// conv_pool_group_sched shared package: FSM encodings, window sizes, helpers.
// Optional feature macro: CONV_SCHED_PERF_EN (performance counters).
package conv_sched_pkg;
  localparam int WIN_PIX = 36;
  localparam int KER_PIX = 25;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  function automatic int grp_base(input int g, input int lanes);
    return g * lanes;
  endfunction
endpackage

// File: rtl/conv_sched_settle_cnt.sv
// Settle counter: gives the combinational lane bank EVAL_CYC cycles per group.
module conv_sched_settle_cnt #(
  parameter int EVAL_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic done
);
  localparam int CW = (EVAL_CYC > 1) ? $clog2(EVAL_CYC) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || start)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign done = en && (cnt == CW'(EVAL_CYC - 1));
endmodule

// File: rtl/conv_pool_group_sched.sv
// Group scheduler for the second binary conv+pool layer lane bank.
// CONV_SCHED_PERF_EN adds busy-cycle and window counters.
module conv_pool_group_sched
  import conv_sched_pkg::*;
#(
  parameter int CHAN_IN  = 18,
  parameter int CHAN_OUT = 60,
  parameter int LANES    = 12,
  parameter int EVAL_CYC = 2,
  localparam int NGRP = CHAN_OUT / LANES,
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          win_valid,
  output logic          win_ready,
  input  logic          win_data   [0:CHAN_IN*WIN_PIX-1],
  output logic          lane_image [0:CHAN_IN*WIN_PIX-1],
  output logic          wt_rd_en,
  output logic [GW-1:0] wt_grp,
  input  logic          lane_pix   [0:LANES-1],
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_pix    [0:CHAN_OUT-1]
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_busy_cyc,
  output logic [15:0]   perf_windows
`endif
);
  if (CHAN_OUT % LANES != 0) begin : g_chk_lanes
    $error("CHAN_OUT must be a multiple of LANES");
  end
  if (EVAL_CYC < 1) begin : g_chk_eval
    $error("EVAL_CYC must be at least 1");
  end

  logic [2:0]    state;
  logic [GW-1:0] grp;
  logic          done;

  conv_sched_settle_cnt #(
    .EVAL_CYC(EVAL_CYC)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .start(state == S_WAIT),
    .en   (state == S_EVAL),
    .done (done)
  );

  assign win_ready = (state == S_IDLE);
  assign wt_rd_en  = (state == S_FETCH);
  assign out_valid = (state == S_OUT);
  // grp only moves on entry to FETCH, so it doubles as the held ROM address
  assign wt_grp    = grp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grp        <= '0;
      lane_image <= '{default: 1'b0};
      out_pix    <= '{default: 1'b0};
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win_valid) begin
            lane_image <= win_data;
            grp        <= '0;
            state      <= S_FETCH;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT:  state <= S_EVAL;
        S_EVAL: begin
          if (done) begin
            for (int g = 0; g < NGRP; g++) begin
              if (grp == GW'(g)) begin
                for (int i = 0; i < LANES; i++)
                  out_pix[grp_base(g, LANES) + i] <= lane_pix[i];
              end
            end
            if (grp == GW'(NGRP - 1)) begin
              state <= S_OUT;
            end else begin
              grp   <= grp + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_OUT: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cyc <= '0;
      perf_windows  <= '0;
    end else begin
      if (state != S_IDLE && perf_busy_cyc != '1)
        perf_busy_cyc <= perf_busy_cyc + 1'b1;
      if (out_valid && out_ready && perf_windows != '1)
        perf_windows <= perf_windows + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_conv_pool_group_sched.sv
// Self-checking bench for conv_pool_group_sched (default and single-group builds).
module tb_conv_pool_group_sched;
  localparam int CI = 18;
  localparam int NW = CI * 36;
  localparam int CO = 60;
  localparam int LN = 12;

  typedef logic [CO-1:0] exp_t;

  typedef struct {
    int seed;
    bit md;
    int rdy_dly;
    bit rdy_hi;
    int nxt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       win_valid, win_ready, wt_rd_en, out_valid, out_ready;
  logic [2:0] wt_grp;
  logic       win_data   [0:NW-1];
  logic       lane_image [0:NW-1];
  logic       lane_pix   [0:LN-1];
  logic       out_pix    [0:CO-1];

  logic       win_valid5, win_ready5, wt_rd_en5, out_valid5, out_ready5;
  logic [0:0] wt_grp5;
  logic       win_data5   [0:NW-1];
  logic       lane_image5 [0:NW-1];
  logic       lane_pix5   [0:CO-1];
  logic       out_pix5    [0:CO-1];

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_busy_cyc, perf_busy_cyc5;
  logic [15:0] perf_windows, perf_windows5;
`endif

  logic mode;
  logic cur  [0:NW-1];
  exp_t sbq[$];
  int   nvec = 0;
  int   nbad = 0;

  always #5 clk = ~clk;

  conv_pool_group_sched dut (
    .clk(clk), .rst(rst),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .lane_image(lane_image),
    .wt_rd_en(wt_rd_en), .wt_grp(wt_grp),
    .lane_pix(lane_pix),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix)
`ifdef CONV_SCHED_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_windows(perf_windows)
`endif
  );

  conv_pool_group_sched #(
    .CHAN_IN(CI), .CHAN_OUT(CO), .LANES(CO), .EVAL_CYC(1)
  ) dut5 (
    .clk(clk), .rst(rst),
    .win_valid(win_valid5), .win_ready(win_ready5),
    .win_data(win_data5), .lane_image(lane_image5),
    .wt_rd_en(wt_rd_en5), .wt_grp(wt_grp5),
    .lane_pix(lane_pix5),
    .out_valid(out_valid5), .out_ready(out_ready5),
    .out_pix(out_pix5)
`ifdef CONV_SCHED_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc5), .perf_windows(perf_windows5)
`endif
  );

  // lane bank stand-in: parity of group, or a group-dependent window tap
  always_comb begin
    for (int i = 0; i < LN; i++) begin
      lane_pix[i] = 1'b0;
      if (mode)
        lane_pix[i] = wt_grp[0];
      else
        lane_pix[i] = lane_image[((int'(wt_grp) * LN + i) * 7) % NW] ^ wt_grp[0];
    end
  end

  always_comb begin
    for (int i = 0; i < CO; i++) begin
      lane_pix5[i] = 1'b0;
      lane_pix5[i] = lane_image5[(i * 11) % NW];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill(input int seed);
    for (int k = 0; k < NW; k++)
      win_data[k] = (((k * seed) + (k / 5) + seed) % 3) == 0;
  endtask

  function automatic exp_t model(input bit md);
    exp_t r;
    int g, i;
    for (int c = 0; c < CO; c++) begin
      g = c / LN;
      i = c % LN;
      if (md)
        r[c] = logic'(g % 2);
      else
        r[c] = cur[((g * LN + i) * 7) % NW] ^ logic'(g % 2);
    end
    return r;
  endfunction

  function automatic exp_t pack_out();
    exp_t r;
    for (int c = 0; c < CO; c++) r[c] = out_pix[c];
    return r;
  endfunction

  // entered and left just after a negedge
  task automatic run_window(input vec_t v);
    int   w, lat;
    bit   img_ok, rdy_ok, stab_ok;
    exp_t snap, e;
    mode      = v.md;
    out_ready = v.rdy_hi;
    fill(v.seed);
    win_valid = 1'b1;
    w = 0;
    while (!win_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 64'(w), 64'd0);
    if (!win_ready) begin
      win_valid = 1'b0;
      return;
    end
    for (int k = 0; k < NW; k++) cur[k] = win_data[k];
    sbq.push_back(model(v.md));
    @(posedge clk);
    #1;
    if (v.nxt >= 0) fill(v.nxt);
    else win_valid = 1'b0;
    lat = -1;
    img_ok = 1'b1;
    rdy_ok = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
      if (win_ready) rdy_ok = 1'b0;
      for (int k = 0; k < NW; k++)
        if (lane_image[k] !== cur[k]) img_ok = 1'b0;
      chk("wt_rd_en", 64'(wt_rd_en), 64'(n % 4 == 0));
      if (n % 4 == 0) chk("wt_grp", 64'(wt_grp), 64'(n / 4));
    end
    chk("latency", 64'(lat), 64'd20);
    chk("busy_win_ready_low", 64'(rdy_ok), 64'd1);
    chk("lane_image_hold", 64'(img_ok), 64'd1);
    if (lat < 0) return;
    snap = pack_out();
    stab_ok = 1'b1;
    for (int r = 1; r < v.rdy_dly; r++) begin
      @(negedge clk);
      if (!out_valid || win_ready || pack_out() !== snap) stab_ok = 1'b0;
    end
    chk("out_hold_stable", 64'(stab_ok), 64'd1);
    out_ready = 1'b1;
    e = sbq.pop_front();
    chk("out_pix", 64'(pack_out()), 64'(e));
    @(posedge clk);
    #1;
    out_ready = v.rdy_hi;
    @(negedge clk);
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("win_ready_back", 64'(win_ready), 64'd1);
  endtask

  task automatic reset_state_chk(input string tag);
    bit z;
    z = 1'b1;
    for (int k = 0; k < NW; k++) if (lane_image[k] !== 1'b0) z = 1'b0;
    chk({tag, "_win_ready"}, 64'(win_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_wt_rd_en"}, 64'(wt_rd_en), 64'd0);
    chk({tag, "_wt_grp"}, 64'(wt_grp), 64'd0);
    chk({tag, "_out_pix"}, 64'(pack_out()), 64'd0);
    chk({tag, "_lane_image"}, 64'(z), 64'd1);
  endtask

  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat5;
    bit   g0ok;
    exp_t e, m;
    tbl[0] = '{seed: 5,  md: 1'b1, rdy_dly: 0,  rdy_hi: 1'b0, nxt: -1};
    tbl[1] = '{seed: 11, md: 1'b0, rdy_dly: 10, rdy_hi: 1'b0, nxt: 3};
    tbl[2] = '{seed: 3,  md: 1'b0, rdy_dly: 2,  rdy_hi: 1'b0, nxt: -1};
    tbl[3] = '{seed: 17, md: 1'b0, rdy_dly: 0,  rdy_hi: 1'b1, nxt: -1};

    rst = 1'b1;
    mode = 1'b0;
    win_valid = 1'b0;
    out_ready = 1'b0;
    win_valid5 = 1'b0;
    out_ready5 = 1'b0;
    fill(1);
    for (int k = 0; k < NW; k++) win_data5[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_state_chk("reset");

    for (int t = 0; t < 4; t++) run_window(tbl[t]);

    // reset in the middle of EVAL
    mode = 1'b0;
    fill(23);
    win_valid = 1'b1;
    for (int k = 0; k < NW; k++) cur[k] = win_data[k];
    @(posedge clk);
    #1 win_valid = 1'b0;
    repeat (8) @(negedge clk);
    m = model(1'b0);
    g0ok = 1'b1;
    for (int c = 0; c < LN; c++) if (out_pix[c] !== m[c]) g0ok = 1'b0;
    chk("mid_eval_grp0_captured", 64'(g0ok), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_state_chk("mid_reset");

    // single group, one settle cycle
    for (int k = 0; k < NW; k++) win_data5[k] = ((k * 13 + 1) % 4) == 0;
    for (int k = 0; k < NW; k++) cur[k] = win_data5[k];
    win_valid5 = 1'b1;
    @(posedge clk);
    #1 win_valid5 = 1'b0;
    lat5 = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("g1_wt_grp", 64'(wt_grp5), 64'd0);
      if (out_valid5) begin
        lat5 = n;
        break;
      end
    end
    chk("g1_latency", 64'(lat5), 64'd3);
    for (int c = 0; c < CO; c++) e[c] = cur[(c * 11) % NW];
    for (int c = 0; c < CO; c++) m[c] = out_pix5[c];
    chk("g1_out_pix", 64'(m), 64'(e));
    out_ready5 = 1'b1;
    @(posedge clk);
    #1 out_ready5 = 1'b0;
    @(negedge clk);
    chk("g1_out_valid_drop", 64'(out_valid5), 64'd0);

`ifdef CONV_SCHED_PERF_EN
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("perf_reset_busy", 64'(perf_busy_cyc), 64'd0);
    run_window('{seed: 7,  md: 1'b0, rdy_dly: 0, rdy_hi: 1'b1, nxt: 9});
    run_window('{seed: 9,  md: 1'b1, rdy_dly: 0, rdy_hi: 1'b1, nxt: 13});
    run_window('{seed: 13, md: 1'b0, rdy_dly: 0, rdy_hi: 1'b1, nxt: -1});
    out_ready = 1'b0;
    chk("perf_windows", 64'(perf_windows), 64'd3);
    chk("perf_busy_cyc", 64'(perf_busy_cyc), 64'd63);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
